// File: rtl/matmul_acc_ctrl.sv
// Matrix-multiply instruction sequencer: feeds operand rows into the systolic
// array, then drives the accumulate load counter and accumulator write strobes.
module matmul_acc_ctrl #(
  parameter int unsigned MATRIX_WIDTH   = 14,
  parameter int unsigned ACC_ADDR_WIDTH = 32,
  parameter int unsigned LENGTH_WIDTH   = 32,
  parameter int unsigned RESULT_DELAY   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_enable,
  input  logic                      i_instr_valid,
  output logic                      o_instr_ready,
  input  logic [ACC_ADDR_WIDTH-1:0] i_instr_acc_addr,
  input  logic [LENGTH_WIDTH-1:0]   i_instr_length,
  input  logic                      i_instr_accumulate,
  output logic                      o_mmu_valid,
  output logic [ACC_ADDR_WIDTH-1:0] o_acc_ctr_start_val,
  output logic                      o_acc_ctr_load,
  output logic                      o_acc_ctr_enable,
  output logic                      o_acc_write_en,
  output logic                      o_acc_accumulate,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned CTR_TAP = RESULT_DELAY - 3;
  localparam int unsigned WR_TAP  = RESULT_DELAY - 1;

  // The counter tap sits two stages ahead of the write tap, so the line needs at least three stages.
  if (RESULT_DELAY < 3 || MATRIX_WIDTH < 1) begin : g_param_check
    $error("matmul_acc_ctrl: RESULT_DELAY must be >= 3 and MATRIX_WIDTH >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                    r_state;
  logic [LENGTH_WIDTH-1:0]   r_remaining;
  logic [ACC_ADDR_WIDTH-1:0] r_start_val;
  logic                      r_accumulate;
  logic                      r_load;
  logic                      r_mmu_valid;
  logic                      r_done;
  logic [RESULT_DELAY-1:0]   r_result_dly;

  logic w_idle;
  logic w_write_en;

  // Everything advances only on enabled edges; a stall freezes all state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_remaining  <= '0;
      r_start_val  <= '0;
      r_accumulate <= 1'b0;
      r_load       <= 1'b0;
      r_mmu_valid  <= 1'b0;
      r_done       <= 1'b0;
      r_result_dly <= '0;
    end else if (i_enable) begin
      r_load       <= 1'b0;
      r_done       <= 1'b0;
      r_result_dly <= {r_result_dly[RESULT_DELAY-2:0], r_mmu_valid};
      case (r_state)
        ST_IDLE: begin
          if (i_instr_valid) begin
            r_start_val  <= i_instr_acc_addr;
            r_accumulate <= i_instr_accumulate;
            r_remaining  <= i_instr_length;
            r_load       <= 1'b1;
            if (i_instr_length == '0) begin
              r_state     <= ST_DRAIN;
              r_mmu_valid <= 1'b0;
            end else begin
              r_state     <= ST_FEED;
              r_mmu_valid <= 1'b1;
            end
          end
        end
        ST_FEED: begin
          r_remaining <= r_remaining - LENGTH_WIDTH'(1);
          if (r_remaining == LENGTH_WIDTH'(1)) begin
            r_state     <= ST_DRAIN;
            r_mmu_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Last row has left the result pipeline once the whole line is empty.
          if (r_result_dly == '0) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_mmu_valid <= 1'b0;
        end
      endcase
    end
  end

  assign w_idle     = (r_state == ST_IDLE);
  assign w_write_en = r_result_dly[WR_TAP] & i_enable;

  // Strobes are masked during a stall so nothing is seen twice.
  assign o_instr_ready       = w_idle & i_enable;
  assign o_mmu_valid         = r_mmu_valid & i_enable;
  assign o_acc_ctr_load      = r_load & i_enable;
  assign o_acc_ctr_enable    = r_result_dly[CTR_TAP] & i_enable;
  assign o_acc_write_en      = w_write_en;
  assign o_acc_accumulate    = r_accumulate & w_write_en;
  assign o_acc_ctr_start_val = r_start_val;
  assign o_busy              = ~w_idle;
  assign o_done              = r_done & i_enable;

endmodule

// File: tb/tb_matmul_acc_ctrl.sv
// Directed bench for matmul_acc_ctrl: instruction table plus back-to-back,
// reset-in-drain and load-counter wrap sequences.
module tb_matmul_acc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_acc_addr;
  logic [31:0] instr_length;
  logic        instr_accumulate;
  logic        mmu_valid;
  logic [31:0] acc_ctr_start_val;
  logic        acc_ctr_load;
  logic        acc_ctr_enable;
  logic        acc_write_en;
  logic        acc_accumulate;
  logic        busy;
  logic        done;

  matmul_acc_ctrl #(
    .MATRIX_WIDTH(14), .ACC_ADDR_WIDTH(32), .LENGTH_WIDTH(32), .RESULT_DELAY(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(enable),
    .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
    .i_instr_acc_addr(instr_acc_addr), .i_instr_length(instr_length),
    .i_instr_accumulate(instr_accumulate), .o_mmu_valid(mmu_valid),
    .o_acc_ctr_start_val(acc_ctr_start_val), .o_acc_ctr_load(acc_ctr_load),
    .o_acc_ctr_enable(acc_ctr_enable), .o_acc_write_en(acc_write_en),
    .o_acc_accumulate(acc_accumulate), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    logic        acc;
    int          stall_at;
    int          stall_n;
    int          exp_load_rel;
    int          exp_first_mmu;
    int          exp_first_wr;
    int          exp_done_rel;
  } vec_t;

  // Per-instruction observations filled by run_instr
  int mmu_cnt, wr_cnt, ce_cnt, load_cnt, done_cnt, accum_cnt;
  int first_mmu, first_wr, first_load, done_rel;
  int stall_leak, ready_early, lead_err, load_sv_err, acc_err, timeout;
  logic [31:0] wr_addr[64];
  int n_addr;

  task automatic run_instr(input logic [31:0] addr, input logic [31:0] len, input logic acc,
                           input int stall_at, input int stall_n);
    bit          accepted;
    int          rel;
    bit          ce_hist[$];
    bit          wr_hist[$];
    logic [31:0] addr_q[$];
    logic [31:0] base, model_cnt;
    mmu_cnt = 0; wr_cnt = 0; ce_cnt = 0; load_cnt = 0; done_cnt = 0; accum_cnt = 0;
    first_mmu = -1; first_wr = -1; first_load = -1; done_rel = -1;
    stall_leak = 0; ready_early = 0; lead_err = 0; load_sv_err = 0; acc_err = 0;
    timeout = 0; n_addr = 0; base = '0; model_cnt = '0;
    accepted = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(posedge clk); #1;
      enable = 1'b1; instr_valid = 1'b1;
      instr_acc_addr = addr; instr_length = len; instr_accumulate = acc;
      @(negedge clk);
      accepted = instr_valid && instr_ready;
    end
    if (!accepted) timeout = 1;
    rel = 0;
    while (accepted && !(done_cnt > 0 && rel >= done_rel + 3)) begin
      @(posedge clk); #1;
      rel++;
      instr_valid = 1'b0;
      enable = !(stall_n > 0 && rel > stall_at && rel <= stall_at + stall_n);
      @(negedge clk);
      if (!enable) begin
        if (mmu_valid || acc_write_en || acc_ctr_enable || acc_ctr_load || done || instr_ready)
          stall_leak++;
      end else begin
        ce_hist.push_back(acc_ctr_enable);
        wr_hist.push_back(acc_write_en);
      end
      if (acc_ctr_load) begin
        load_cnt++;
        if (first_load < 0) first_load = rel;
        if (acc_ctr_start_val != addr) load_sv_err++;
        base = acc_ctr_start_val; model_cnt = acc_ctr_start_val;
      end
      if (mmu_valid) begin
        mmu_cnt++;
        if (first_mmu < 0) first_mmu = rel;
      end
      if (acc_ctr_enable) begin
        ce_cnt++;
        addr_q.push_back(model_cnt);
        model_cnt = (model_cnt - base == 32'd13) ? base : model_cnt + 32'd1;
      end
      if (acc_write_en) begin
        wr_cnt++;
        if (first_wr < 0) first_wr = rel;
        if (acc_accumulate) accum_cnt++;
        if (addr_q.size() > 0 && n_addr < 64) begin
          wr_addr[n_addr] = addr_q.pop_front();
          n_addr++;
        end
      end
      if (acc_accumulate && !acc_write_en) acc_err++;
      if (instr_ready && done_cnt == 0 && !done) ready_early++;
      if (done) begin
        done_cnt++;
        if (done_rel < 0) done_rel = rel;
      end
      if (rel >= 150) begin
        timeout = 1;
        break;
      end
    end
    for (int i = 0; i < wr_hist.size(); i++)
      if (wr_hist[i] != ((i >= 2) ? ce_hist[i-2] : 1'b0)) lead_err++;
    enable = 1'b1;
  endtask

  vec_t vecs[6];

  initial begin
    int          rel;
    int          b_acc_rel, a_done_rel, b_done_rel, rdy_early, loads_21;
    logic [31:0] sv_20, sv_21;
    int          bad_out, late_evt;

    vecs[0] = '{32'h40,       32'd5,  1'b0, 0,  0, 1, 1,  17, 23};
    vecs[1] = '{32'h0,        32'd0,  1'b0, 0,  0, 1, -1, -1, 2};
    vecs[2] = '{32'h100,      32'd20, 1'b1, 5,  3, 1, 1,  20, 41};
    vecs[3] = '{32'hFFFF_FFF0, 32'd1, 1'b1, 0,  0, 1, 1,  17, 19};
    vecs[4] = '{32'h80,       32'd3,  1'b0, 10, 2, 1, 1,  19, 23};
    vecs[5] = '{32'hC0,       32'd2,  1'b1, 0,  2, 3, 3,  19, 22};

    rst_n = 1'b0; enable = 1'b1; instr_valid = 1'b0;
    instr_acc_addr = '0; instr_length = '0; instr_accumulate = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", instr_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_start_val", acc_ctr_start_val, 0);
    check("reset_strobes", {mmu_valid, acc_write_en, acc_ctr_enable, acc_ctr_load, acc_accumulate, done}, 0);

    for (int v = 0; v < 6; v++) begin
      run_instr(vecs[v].addr, vecs[v].len, vecs[v].acc, vecs[v].stall_at, vecs[v].stall_n);
      check($sformatf("v%0d_timeout", v), timeout, 0);
      check($sformatf("v%0d_mmu_cnt", v), mmu_cnt, vecs[v].len);
      check($sformatf("v%0d_wr_cnt", v), wr_cnt, vecs[v].len);
      check($sformatf("v%0d_ctr_en_cnt", v), ce_cnt, vecs[v].len);
      check($sformatf("v%0d_accum_cnt", v), accum_cnt, vecs[v].acc ? vecs[v].len : 0);
      check($sformatf("v%0d_load_cnt", v), load_cnt, 1);
      check($sformatf("v%0d_load_rel", v), first_load, vecs[v].exp_load_rel);
      check($sformatf("v%0d_load_start_val", v), load_sv_err, 0);
      check($sformatf("v%0d_first_mmu", v), first_mmu, vecs[v].exp_first_mmu);
      check($sformatf("v%0d_first_wr", v), first_wr, vecs[v].exp_first_wr);
      check($sformatf("v%0d_done_rel", v), done_rel, vecs[v].exp_done_rel);
      check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
      check($sformatf("v%0d_stall_leak", v), stall_leak, 0);
      check($sformatf("v%0d_ready_early", v), ready_early, 0);
      check($sformatf("v%0d_ctr_lead", v), lead_err, 0);
      check($sformatf("v%0d_acc_unqualified", v), acc_err, 0);
      check($sformatf("v%0d_start_val_held", v), acc_ctr_start_val, vecs[v].addr);
    end

    // Load counter wrap: 15 rows from 0x200 give 0x200..0x20D then 0x200
    run_instr(32'h200, 32'd15, 1'b0, 0, 0);
    check("wrap_timeout", timeout, 0);
    check("wrap_n_addr", n_addr, 15);
    check("wrap_addr0", wr_addr[0], 32'h200);
    check("wrap_addr13", wr_addr[13], 32'h20D);
    check("wrap_addr14", wr_addr[14], 32'h200);
    check("wrap_done_rel", done_rel, 33);

    // Back-to-back: second instruction held off until first done
    b_acc_rel = -1; a_done_rel = -1; b_done_rel = -1; rdy_early = 0; loads_21 = 0;
    sv_20 = '0; sv_21 = '0;
    @(posedge clk); #1;
    instr_valid = 1'b1; instr_acc_addr = 32'h1000; instr_length = 32'd2; instr_accumulate = 1'b0;
    @(negedge clk);
    check("b2b_first_accept", instr_ready, 1);
    rel = 0;
    while (rel < 60) begin
      @(posedge clk); #1;
      rel++;
      if (b_acc_rel < 0) begin
        instr_acc_addr = 32'h2000; instr_length = 32'd1; instr_accumulate = 1'b1;
      end else begin
        instr_valid = 1'b0;
      end
      @(negedge clk);
      if (instr_valid && instr_ready && b_acc_rel < 0) b_acc_rel = rel;
      if (instr_ready && rel < 20) rdy_early++;
      if (done && a_done_rel < 0) a_done_rel = rel;
      else if (done && b_done_rel < 0) b_done_rel = rel;
      if (rel == 20) sv_20 = acc_ctr_start_val;
      if (rel == 21) begin
        sv_21 = acc_ctr_start_val;
        loads_21 = acc_ctr_load;
      end
      if (b_done_rel >= 0) break;
    end
    instr_valid = 1'b0;
    check("b2b_ready_early", rdy_early, 0);
    check("b2b_first_done", a_done_rel, 20);
    check("b2b_second_accept", b_acc_rel, 20);
    check("b2b_start_val_before", sv_20, 32'h1000);
    check("b2b_start_val_after", sv_21, 32'h2000);
    check("b2b_second_load", loads_21, 1);
    check("b2b_second_done", b_done_rel, 39);

    // Reset while draining aborts the instruction without done
    @(posedge clk); #1;
    instr_valid = 1'b1; instr_acc_addr = 32'h3000; instr_length = 32'd2; instr_accumulate = 1'b1;
    @(negedge clk);
    check("rst_drain_accept", instr_ready, 1);
    for (int r = 1; r <= 10; r++) begin
      @(posedge clk); #1;
      instr_valid = 1'b0;
    end
    @(negedge clk);
    check("rst_drain_busy_before", busy, 1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_drain_busy", busy, 0);
    check("rst_drain_ready", instr_ready, 1);
    check("rst_drain_start_val", acc_ctr_start_val, 0);
    check("rst_drain_strobes", {mmu_valid, acc_write_en, acc_ctr_enable, acc_ctr_load, acc_accumulate, done}, 0);
    bad_out = 0; late_evt = 0;
    for (int r = 0; r < 30; r++) begin
      @(negedge clk);
      if (done || acc_write_en || acc_ctr_enable || mmu_valid) late_evt++;
      if (busy) bad_out++;
    end
    check("rst_drain_no_late_events", late_evt, 0);
    check("rst_drain_stays_idle", bad_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
